// File: rtl/addr_gen32_if.sv
// Control, configuration and address bus of the two-level address generator.
interface addr_gen32_if #(
    parameter int ADDR_W = 11
);
    logic              addr_gen32_init;
    logic              addr_gen32_in_disable;
    logic [ADDR_W-1:0] addr_gen32_start;
    logic [ADDR_W-1:0] addr_gen32_incr;
    logic [ADDR_W-1:0] addr_gen32_shift;
    logic [9:0]        addr_gen32_per;
    logic [9:0]        addr_gen32_iter;
    logic [4:0]        addr_gen32_delay;
    logic [ADDR_W-1:0] addr_gen32_addr;
    logic              addr_gen32_valid;
    logic              addr_gen32_done;

    modport master (
        output addr_gen32_init, addr_gen32_in_disable, addr_gen32_start,
               addr_gen32_incr, addr_gen32_shift, addr_gen32_per,
               addr_gen32_iter, addr_gen32_delay,
        input  addr_gen32_addr, addr_gen32_valid, addr_gen32_done
    );

    modport slave (
        input  addr_gen32_init, addr_gen32_in_disable, addr_gen32_start,
               addr_gen32_incr, addr_gen32_shift, addr_gen32_per,
               addr_gen32_iter, addr_gen32_delay,
        output addr_gen32_addr, addr_gen32_valid, addr_gen32_done
    );
endinterface

// File: rtl/addr_gen32.sv
// Two-level address generator: steps by incr inside a period, by shift at
// each period boundary, for iter periods after an optional start delay.
// The address is emitted on the edge after it is selected, so every output
// comes straight from a flop.
module addr_gen32 #(
    parameter int ADDR_W = 11
) (
    input  logic         addr_gen32_clk,
    input  logic         addr_gen32_reset,
    addr_gen32_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_t;

    state_t            r_state, w_nxt;
    logic [ADDR_W-1:0] r_incr, r_shift, r_cur, r_addr;
    logic [9:0]        r_per, r_iter, r_per_cnt, r_iter_cnt;
    logic [4:0]        r_dly_cnt;
    logic              r_valid, r_done;
    logic              w_per_end, w_last;

    assign w_per_end = (r_per_cnt == r_per - 10'd1);
    assign w_last    = w_per_end && (r_iter_cnt == r_iter - 10'd1);

    // State register
    always_ff @(posedge addr_gen32_clk or negedge addr_gen32_reset) begin
        if (!addr_gen32_reset) r_state <= IDLE;
        else                   r_state <= w_nxt;
    end

    // Next state: init wins over stall, stall freezes the state
    always_comb begin
        w_nxt = r_state;
        if (bus.addr_gen32_init) begin
            if (bus.addr_gen32_per == 10'd0 || bus.addr_gen32_iter == 10'd0)
                w_nxt = DONE;
            else if (bus.addr_gen32_delay != 5'd0)
                w_nxt = DELAY;
            else
                w_nxt = RUN;
        end else if (!bus.addr_gen32_in_disable) begin
            case (r_state)
                DELAY:   if (r_dly_cnt <= 5'd1) w_nxt = RUN;
                RUN:     if (w_last) w_nxt = DONE;
                default: w_nxt = r_state;
            endcase
        end
    end

    // Configuration latch, counters and registered outputs
    always_ff @(posedge addr_gen32_clk or negedge addr_gen32_reset) begin
        if (!addr_gen32_reset) begin
            r_incr     <= '0;
            r_shift    <= '0;
            r_per      <= '0;
            r_iter     <= '0;
            r_cur      <= '0;
            r_addr     <= '0;
            r_per_cnt  <= '0;
            r_iter_cnt <= '0;
            r_dly_cnt  <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else if (bus.addr_gen32_init) begin
            r_incr     <= bus.addr_gen32_incr;
            r_shift    <= bus.addr_gen32_shift;
            r_per      <= bus.addr_gen32_per;
            r_iter     <= bus.addr_gen32_iter;
            r_cur      <= bus.addr_gen32_start;
            r_dly_cnt  <= bus.addr_gen32_delay;
            r_per_cnt  <= '0;
            r_iter_cnt <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else if (bus.addr_gen32_in_disable) begin
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                DELAY: r_dly_cnt <= r_dly_cnt - 5'd1;
                RUN: begin
                    r_valid <= 1'b1;
                    r_addr  <= r_cur;
                    if (w_per_end) begin
                        r_per_cnt  <= '0;
                        r_iter_cnt <= r_iter_cnt + 10'd1;
                        r_cur      <= r_cur + r_shift;
                    end else begin
                        r_per_cnt  <= r_per_cnt + 10'd1;
                        r_cur      <= r_cur + r_incr;
                    end
                end
                DONE:    r_done <= 1'b1;
                default: r_done <= r_done;
            endcase
        end
    end

    assign bus.addr_gen32_addr  = r_addr;
    assign bus.addr_gen32_valid = r_valid;
    assign bus.addr_gen32_done  = r_done;
endmodule

// File: tb/tb_addr_gen32.sv
// Self-checking bench for addr_gen32: directed scenarios plus randomized
// sequences, compared cycle by cycle against a queue-based reference.
module tb_addr_gen32;
    localparam int ADDR_W = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    addr_gen32_if #(.ADDR_W(ADDR_W)) bus ();

    addr_gen32 #(.ADDR_W(ADDR_W)) dut (
        .addr_gen32_clk   (clk),
        .addr_gen32_reset (rst_n),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    // reference: the whole address list is computed at init and popped
    logic [ADDR_W-1:0] q[$];
    int                m_dly;
    bit                m_active;
    bit                m_valid, m_done;
    logic [ADDR_W-1:0] m_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 0;
        m_valid  = 0;
        m_done   = 0;
        m_addr   = '0;
        m_dly    = 0;
    endtask

    task automatic model_init();
        logic [ADDR_W-1:0] a;
        q.delete();
        a = bus.addr_gen32_start;
        for (int i = 0; i < int'(bus.addr_gen32_per == 0 ? 0 : bus.addr_gen32_iter); i++)
            for (int j = 0; j < int'(bus.addr_gen32_per); j++) begin
                q.push_back(a);
                a = a + ((j == int'(bus.addr_gen32_per) - 1) ? bus.addr_gen32_shift
                                                              : bus.addr_gen32_incr);
            end
        m_dly    = int'(bus.addr_gen32_delay);
        if (q.size() == 0) m_dly = 0;
        m_active = 1;
        m_valid  = 0;
        m_done   = 0;
    endtask

    task automatic cfg(input int st, input int inc, input int sh, input int per,
                       input int it, input int dly);
        bus.addr_gen32_start = ADDR_W'(st);
        bus.addr_gen32_incr  = ADDR_W'(inc);
        bus.addr_gen32_shift = ADDR_W'(sh);
        bus.addr_gen32_per   = 10'(per);
        bus.addr_gen32_iter  = 10'(it);
        bus.addr_gen32_delay = 5'(dly);
    endtask

    // one clock cycle: inputs seen at this edge, outputs checked just after
    task automatic step(input bit init, input bit dis, input string tag);
        @(negedge clk);
        bus.addr_gen32_init       = init;
        bus.addr_gen32_in_disable = dis;
        @(posedge clk);
        if (init) model_init();
        else if (dis) m_valid = 0;
        else if (!m_active) m_valid = 0;
        else if (m_dly > 0) begin m_dly--; m_valid = 0; end
        else if (q.size() != 0) begin m_addr = q.pop_front(); m_valid = 1; end
        else begin m_valid = 0; m_done = 1; end
        #1;
        if (init) cfg($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        chk({tag, ".valid"}, 32'(bus.addr_gen32_valid), 32'(m_valid));
        chk({tag, ".done"},  32'(bus.addr_gen32_done),  32'(m_done));
        if (m_valid) chk({tag, ".addr"}, 32'(bus.addr_gen32_addr), 32'(m_addr));
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, tag);
    endtask

    initial begin
        bus.addr_gen32_init = 0;
        bus.addr_gen32_in_disable = 0;
        cfg(0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        chk("rst.addr",  32'(bus.addr_gen32_addr), 0);
        chk("rst.valid", 32'(bus.addr_gen32_valid), 0);
        chk("rst.done",  32'(bus.addr_gen32_done), 0);
        #22 rst_n = 1'b1;

        // start a sequence, then reset mid-stream without a clock edge
        cfg(4, 2, 1, 3, 2, 0);
        step(1, 0, "pre");
        run(3, "pre");
        @(negedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst.addr",  32'(bus.addr_gen32_addr), 0);
        chk("mid_rst.valid", 32'(bus.addr_gen32_valid), 0);
        chk("mid_rst.done",  32'(bus.addr_gen32_done), 0);
        @(negedge clk); rst_n = 1'b1;
        run(3, "idle");

        // basic sequence: 4,6,8,9,11,13 in cycles 1-6, done from 7
        cfg(4, 2, 1, 3, 2, 0);
        step(1, 0, "basic");
        run(9, "basic");

        // delay 3 with a stall in cycle 6
        cfg(4, 2, 1, 3, 2, 3);
        step(1, 0, "dly");
        run(5, "dly");
        step(0, 1, "dly");
        run(6, "dly");

        // wrap with negative shift
        cfg(2046, 1, 12'h7FC, 4, 2, 0);
        step(1, 0, "wrap");
        run(10, "wrap");

        // degenerate config
        cfg(7, 1, 1, 0, 5, 3);
        step(1, 0, "degen");
        run(6, "degen");

        // restart while the 3rd address would be emitted
        cfg(4, 2, 1, 3, 2, 0);
        step(1, 0, "rstrt");
        run(2, "rstrt");
        cfg(100, 1, 0, 2, 1, 0);
        step(1, 0, "rstrt");
        run(5, "rstrt");

        // init together with stall
        cfg(20, 3, 5, 2, 2, 1);
        step(1, 1, "initdis");
        step(0, 1, "initdis");
        step(0, 1, "initdis");
        run(8, "initdis");

        // randomized sequences with stalls and occasional restarts
        for (int s = 0; s < 40; s++) begin
            cfg($urandom, $urandom, $urandom, $urandom_range(0, 5),
                $urandom_range(0, 4), $urandom_range(0, 4));
            step(1, $urandom_range(0, 3) == 0, "rand");
            for (int c = 0; c < 40; c++)
                if ($urandom_range(0, 49) == 0) begin
                    cfg($urandom, $urandom, $urandom, $urandom_range(0, 5),
                        $urandom_range(0, 4), $urandom_range(0, 4));
                    step(1, $urandom_range(0, 1) == 1, "rand");
                end else
                    step(0, $urandom_range(0, 4) == 0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
